// File: rtl/rns18_pkg.sv
// Shared constants and types for the 18-bit RNS forward converter.
// Holds the default primary-base moduli, digit/input widths, the converter
// FSM state type and the residue digit type.
package rns18_pkg;

  localparam int unsigned IN_WIDTH   = 64;
  localparam int unsigned DATA_WIDTH = 18;

  localparam int unsigned MOD1 = 78125;   // 5^7
  localparam int unsigned MOD2 = 131072;  // 2^17
  localparam int unsigned MOD3 = 177147;  // 3^11
  localparam int unsigned MOD4 = 199927;  // 7 * 13^4

  typedef logic [DATA_WIDTH-1:0] residue_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StFix   = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/rns_forward_convert18_if.sv
// Handshake bundle for the RNS forward converter.
//   bin_in/in_valid/in_ready   : input side, signed binary operand
//   r1_out..r4_out/sign_out    : residue digits and echoed sign
//   out_valid/out_ready        : output side
// master: producer/consumer driving the converter; slave: the converter.
interface rns_forward_convert18_if
  import rns18_pkg::*;
#(
  parameter int unsigned InWidth   = IN_WIDTH,
  parameter int unsigned DataWidth = DATA_WIDTH
);

  logic [InWidth-1:0]   bin_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [DataWidth-1:0] r1_out;
  logic [DataWidth-1:0] r2_out;
  logic [DataWidth-1:0] r3_out;
  logic [DataWidth-1:0] r4_out;
  logic                 sign_out;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output bin_in, in_valid, out_ready,
    input  in_ready, r1_out, r2_out, r3_out, r4_out, sign_out, out_valid
  );

  modport slave (
    input  bin_in, in_valid, out_ready,
    output in_ready, r1_out, r2_out, r3_out, r4_out, sign_out, out_valid
  );

endinterface

// File: rtl/rns_digit_acc.sv
// One residue digit of the forward converter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : zero the accumulator
//   step_i     : r <- (2r + bit_i) mod MODULUS
//   bit_i      : next magnitude bit, MSB first
//   fix_i      : apply sign correction to the accumulator
//   neg_i      : operand is negative
//   res_o      : residue with sign correction applied (combinational)
module rns_digit_acc
  import rns18_pkg::*;
#(
  parameter int unsigned MODULUS   = MOD1,
  parameter int unsigned DataWidth = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 step_i,
  input  logic                 bit_i,
  input  logic                 fix_i,
  input  logic                 neg_i,
  output logic [DataWidth-1:0] res_o
);

  localparam logic [DataWidth:0] ModW = (DataWidth + 1)'(MODULUS);

  logic [DataWidth-1:0] acc_q, acc_d;
  logic [DataWidth:0]   t;
  logic [DataWidth-1:0] step_val;

  always_comb begin
    // acc < MODULUS, so 2*acc+1 < 2*MODULUS and one subtract suffices.
    t        = {acc_q, bit_i};
    step_val = (t >= ModW) ? DataWidth'(t - ModW) : t[DataWidth-1:0];
    // A zero residue of a negative value must stay 0, not become MODULUS.
    res_o    = (neg_i && (acc_q != '0)) ? DataWidth'(ModW - {1'b0, acc_q}) : acc_q;

    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d = step_val;
    end else if (fix_i) begin
      acc_d = res_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/rns_forward_convert18.sv
// Sequential binary-to-RNS forward converter. Converts a signed IN_WIDTH
// operand into four residues, one magnitude bit per cycle, then corrects
// for sign. 65 cycles from acceptance to out_valid.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   conv_if    : slave side of the handshake bundle (see interface file)
module rns_forward_convert18
  import rns18_pkg::*;
#(
  parameter int unsigned InWidth   = IN_WIDTH,
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned Mod1      = MOD1,
  parameter int unsigned Mod2      = MOD2,
  parameter int unsigned Mod3      = MOD3,
  parameter int unsigned Mod4      = MOD4
) (
  input logic                    clk,
  input logic                    reset,
  rns_forward_convert18_if.slave conv_if
);

  localparam int unsigned CntW = $clog2(InWidth);
  localparam logic [CntW-1:0] CntLast = CntW'(InWidth - 1);

  state_e               state_q, state_d;
  logic [InWidth-1:0]   mag_q, mag_d;
  logic                 neg_q, neg_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 clr, step, fix;
  logic [DataWidth-1:0] res1, res2, res3, res4;
  logic [DataWidth-1:0] r1_q, r2_q, r3_q, r4_q;
  logic                 sign_q;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      StIdle: begin
        if (conv_if.in_valid) begin
          neg_d   = conv_if.bin_in[InWidth-1];
          // Unsigned view of the negation maps the most negative value to 2^(InWidth-1).
          mag_d   = conv_if.bin_in[InWidth-1] ? -conv_if.bin_in : conv_if.bin_in;
          cnt_d   = '0;
          clr     = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        step  = 1'b1;
        mag_d = mag_q << 1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end
      end
      StFix: begin
        fix     = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (conv_if.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  rns_digit_acc #(.MODULUS(Mod1), .DataWidth(DataWidth)) u_acc1 (
    .clk(clk), .reset(reset), .clr_i(clr), .step_i(step), .bit_i(mag_q[InWidth-1]),
    .fix_i(fix), .neg_i(neg_q), .res_o(res1)
  );
  rns_digit_acc #(.MODULUS(Mod2), .DataWidth(DataWidth)) u_acc2 (
    .clk(clk), .reset(reset), .clr_i(clr), .step_i(step), .bit_i(mag_q[InWidth-1]),
    .fix_i(fix), .neg_i(neg_q), .res_o(res2)
  );
  rns_digit_acc #(.MODULUS(Mod3), .DataWidth(DataWidth)) u_acc3 (
    .clk(clk), .reset(reset), .clr_i(clr), .step_i(step), .bit_i(mag_q[InWidth-1]),
    .fix_i(fix), .neg_i(neg_q), .res_o(res3)
  );
  rns_digit_acc #(.MODULUS(Mod4), .DataWidth(DataWidth)) u_acc4 (
    .clk(clk), .reset(reset), .clr_i(clr), .step_i(step), .bit_i(mag_q[InWidth-1]),
    .fix_i(fix), .neg_i(neg_q), .res_o(res4)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      r4_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      // Outputs capture the sign-corrected residues on the FIX->DONE edge only.
      if (fix) begin
        r1_q   <= res1;
        r2_q   <= res2;
        r3_q   <= res3;
        r4_q   <= res4;
        sign_q <= neg_q;
      end
    end
  end

  assign conv_if.in_ready  = (state_q == StIdle);
  assign conv_if.out_valid = (state_q == StDone);
  assign conv_if.r1_out    = r1_q;
  assign conv_if.r2_out    = r2_q;
  assign conv_if.r3_out    = r3_q;
  assign conv_if.r4_out    = r4_q;
  assign conv_if.sign_out  = sign_q;

endmodule

// File: tb/tb_rns_forward_convert18.sv
module tb_rns_forward_convert18;
  import rns18_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  rns_forward_convert18_if conv_if ();

  rns_forward_convert18 dut (
    .clk(clk),
    .reset(reset),
    .conv_if(conv_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] x;
    logic [17:0] e1, e2, e3, e4;
    logic        es;
    logic        pre_rdy;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [17:0] golden(input logic [63:0] x, input int unsigned m);
    logic signed [127:0] xs, ms, r;
    xs = {{64{x[63]}}, x};
    ms = 128'(m);
    r  = xs % ms;
    if (r < 0) r = r + ms;
    return r[17:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic accept(input string tag, input logic [63:0] x);
    int n;
    n = 0;
    while (!conv_if.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({tag, " idle timeout"}, 64'd0, 64'd1);
    conv_if.bin_in   = x;
    conv_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    conv_if.in_valid = 1'b0;
  endtask

  // Called on the negedge after the acceptance edge.
  task automatic await_valid(input string tag);
    int lat;
    logic saw_ready;
    lat = 0;
    saw_ready = 1'b0;
    while (!conv_if.out_valid && lat < 200) begin
      if (conv_if.in_ready) saw_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd65);
    chk({tag, " in_ready low while busy"}, 64'(saw_ready), 64'd0);
  endtask

  task automatic check_res(input string tag, input logic [17:0] e1, input logic [17:0] e2,
                           input logic [17:0] e3, input logic [17:0] e4, input logic es);
    chk({tag, " r1"}, 64'(conv_if.r1_out), 64'(e1));
    chk({tag, " r2"}, 64'(conv_if.r2_out), 64'(e2));
    chk({tag, " r3"}, 64'(conv_if.r3_out), 64'(e3));
    chk({tag, " r4"}, 64'(conv_if.r4_out), 64'(e4));
    chk({tag, " sign"}, 64'(conv_if.sign_out), 64'(es));
    chk({tag, " range"}, 64'((conv_if.r1_out < MOD1) && (conv_if.r2_out < MOD2) &&
                             (conv_if.r3_out < MOD3) && (conv_if.r4_out < MOD4)), 64'd1);
  endtask

  task automatic release_out(input string tag);
    conv_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    conv_if.out_ready = 1'b0;
    chk({tag, " out_valid drops"}, 64'(conv_if.out_valid), 64'd0);
    chk({tag, " in_ready returns"}, 64'(conv_if.in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] neg_min, pos_max;
    logic        ok;
    n_checks = 0;
    n_errors = 0;
    neg_min  = 64'h8000_0000_0000_0000;
    pos_max  = 64'h7FFF_FFFF_FFFF_FFFF;

    vecs[0] = '{x: 64'd0, e1: 18'd0, e2: 18'd0, e3: 18'd0, e4: 18'd0, es: 1'b0, pre_rdy: 1'b0};
    vecs[1] = '{x: 64'hFFFF_FFFF_FFFF_FFFF, e1: 18'h1312C, e2: 18'h1FFFF, e3: 18'h2B3FA,
                e4: 18'h30CF6, es: 1'b1, pre_rdy: 1'b0};
    vecs[2] = '{x: 64'd1000000, e1: 18'd62500, e2: 18'd82496, e3: 18'd114265, e4: 18'd365,
                es: 1'b0, pre_rdy: 1'b1};
    vecs[3] = '{x: -64'sd1000000, e1: 18'd15625, e2: 18'd48576, e3: 18'd62882, e4: 18'd199562,
                es: 1'b1, pre_rdy: 1'b0};
    vecs[4] = '{x: 64'd1, e1: 18'd1, e2: 18'd1, e3: 18'd1, e4: 18'd1, es: 1'b0, pre_rdy: 1'b0};
    vecs[5] = '{x: 64'd78125, e1: 18'd0, e2: 18'd78125, e3: 18'd78125, e4: 18'd78125,
                es: 1'b0, pre_rdy: 1'b0};
    // Zero digit of a negative value must stay 0.
    vecs[6] = '{x: -64'sd78125, e1: 18'd0, e2: 18'd52947, e3: 18'd99022, e4: 18'd121802,
                es: 1'b1, pre_rdy: 1'b0};
    vecs[7] = '{x: neg_min, e1: golden(neg_min, MOD1), e2: golden(neg_min, MOD2),
                e3: golden(neg_min, MOD3), e4: golden(neg_min, MOD4), es: 1'b1, pre_rdy: 1'b0};
    vecs[8] = '{x: pos_max, e1: golden(pos_max, MOD1), e2: golden(pos_max, MOD2),
                e3: golden(pos_max, MOD3), e4: golden(pos_max, MOD4), es: 1'b0, pre_rdy: 1'b1};

    reset             = 1'b1;
    conv_if.bin_in    = '0;
    conv_if.in_valid  = 1'b0;
    conv_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", 64'(conv_if.in_ready), 64'd1);
    chk("reset out_valid", 64'(conv_if.out_valid), 64'd0);
    check_res("reset", 18'd0, 18'd0, 18'd0, 18'd0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      conv_if.out_ready = vecs[i].pre_rdy;
      accept(tag, vecs[i].x);
      await_valid(tag);
      check_res(tag, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].e4, vecs[i].es);
      release_out(tag);
    end

    // Back-pressure: result held for 20 cycles while a competing input is offered.
    accept("bp", -64'sd1000000);
    await_valid("bp");
    ok = 1'b1;
    conv_if.in_valid = 1'b1;
    conv_if.bin_in   = 64'd12345;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (conv_if.r1_out !== 18'd15625 || conv_if.r2_out !== 18'd48576 ||
          conv_if.r3_out !== 18'd62882 || conv_if.r4_out !== 18'd199562 ||
          conv_if.sign_out !== 1'b1 || conv_if.in_ready !== 1'b0 ||
          conv_if.out_valid !== 1'b1)
        ok = 1'b0;
    end
    chk("bp held stable", 64'(ok), 64'd1);
    conv_if.in_valid = 1'b0;
    release_out("bp");
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (conv_if.out_valid !== 1'b0 || conv_if.in_ready !== 1'b1) ok = 1'b0;
    end
    chk("bp ignored input", 64'(ok), 64'd1);

    // Reset in the middle of SHIFT aborts and clears the held result.
    accept("rst", 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst in_ready", 64'(conv_if.in_ready), 64'd1);
    chk("rst out_valid", 64'(conv_if.out_valid), 64'd0);
    check_res("rst", 18'd0, 18'd0, 18'd0, 18'd0, 1'b0);
    accept("post", 64'd1);
    await_valid("post");
    check_res("post", 18'd1, 18'd1, 18'd1, 18'd1, 1'b0);
    release_out("post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
